// File: rtl/dso_pkg.sv
// Shared types and constants for the oscilloscope capture path.
package dso_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        ARMED,
        POST,
        DONE
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;

endpackage

// File: rtl/trig_detect.sv
// Level/slope trigger detector with clamped hysteresis.
// hit is combinational on the current sample; the arming flag is registered,
// so a sample that arms the flag can never also be the hit.
module trig_detect
    import dso_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int HYST   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] level,
    input  logic              slope,
    input  logic              clr,
    output logic              hit
);

    localparam logic [DATA_W:0] MAX_V  = {1'b0, {DATA_W{1'b1}}};
    localparam logic [DATA_W:0] HYST_V = (DATA_W + 1)'(HYST);

    logic [DATA_W:0]   level_x;
    logic [DATA_W:0]   hi_sum;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
    logic              arm_cond;
    logic              hit_cond;
    logic              flag;

    // Clamped hysteresis bounds and the arm/hit conditions for the selected slope.
    // A bound clamped onto the rail can make arming impossible; that is intended.
    always_comb begin
        // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
        level_x  = {1'b0, level};
        lo       = (level_x > HYST_V) ? DATA_W'(level_x - HYST_V) : '0;
        hi_sum   = level_x + HYST_V;
        hi       = (hi_sum > MAX_V) ? '1 : hi_sum[DATA_W-1:0];
        arm_cond = 1'b0;
        hit_cond = 1'b0;
        if (slope) begin
            arm_cond = (s_data > hi);
            hit_cond = (s_data <= level);
        end else begin
            arm_cond = (s_data < lo);
            hit_cond = (s_data >= level);
        end
    end

    // Arming flag: set by a valid sample beyond the far bound, held until cleared.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            flag <= 1'b0;
        end else if (s_valid && arm_cond) begin
            flag <= 1'b1;
        end
    end

    assign hit = s_valid && flag && hit_cond;

endmodule

// File: rtl/trigger_capture.sv
// Trigger/capture controller: fills the circular sample RAM with a frame of
// PRE_TRIG pre-trigger samples, the trigger sample and the post-trigger tail,
// then freezes the buffer until the display (or user, in single mode) releases it.
module trigger_capture
    import dso_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PRE_TRIG = 128,
    parameter int HYST     = 16,
    parameter int AUTO_TO  = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic              rearm,
    input  logic              arm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] start_addr,
    output logic              frame_ready,
    output logic              auto_trig
);

    localparam int                POST_N    = (1 << ADDR_W) - PRE_TRIG - 1;
    localparam int                TO_W      = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
    localparam logic [ADDR_W-1:0] PRE_V     = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TO - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              wr_go;
    logic              trig_go;
    logic              auto_go;
    logic              hit;
    logic              detecting;

    // The detector sees samples only while capturing toward a trigger; its flag
    // is held clear everywhere else, so it starts clean on every PRETRIG entry.
    assign detecting = (state == PRETRIG) || (state == ARMED);

    // The final post-trigger write lands in the first DONE cycle; the frame is
    // only presented (and releasable) once that write has gone out.
    assign frame_ready = (state == DONE) && !wr_en;

    trig_detect #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_trig_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .s_data  (s_data),
        .s_valid (s_valid && detecting),
        .level   (trig_level),
        .slope   (trig_slope),
        .clr     (!detecting),
        .hit     (hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus per-cycle write/trigger decisions.
    always_comb begin
        state_next = state;
        wr_go      = 1'b0;
        trig_go    = 1'b0;
        auto_go    = 1'b0;
        case (state)
            IDLE: state_next = PRETRIG;
            PRETRIG: begin
                if (PRE_TRIG == 0) begin
                    state_next = ARMED;
                end else if (s_valid) begin
                    wr_go = 1'b1;
                    if (cnt == PRE_LAST) state_next = ARMED;
                end
            end
            ARMED: begin
                if (s_valid) begin
                    wr_go = 1'b1;
                    if (hit) begin
                        trig_go = 1'b1;
                    end else if (trig_mode == MODE_AUTO && to_cnt == TO_LAST) begin
                        trig_go = 1'b1;
                        auto_go = 1'b1;
                    end
                    if (trig_go) state_next = (POST_N == 0) ? DONE : POST;
                end
            end
            POST: begin
                if (s_valid) begin
                    wr_go = 1'b1;
                    if (cnt == POST_LAST) state_next = DONE;
                end
            end
            DONE: begin
                if (frame_ready && ((trig_mode == MODE_SINGLE) ? arm : rearm)) begin
                    state_next = PRETRIG;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered write port, circular pointer, phase counters and trigger bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            start_addr <= '0;
            auto_trig  <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
            to_cnt     <= '0;
        end else begin
            wr_en <= wr_go;
            if (wr_go) begin
                wr_addr <= ptr;
                wr_data <= s_data;
                ptr     <= ptr + ADDR_W'(1);
            end
            // cnt counts writes within the current phase only.
            if (state_next != state) begin
                cnt <= '0;
            end else if (wr_go) begin
                cnt <= cnt + ADDR_W'(1);
            end
            // Saturates so a long normal-mode wait cannot wrap into a timeout.
            if (state != ARMED) begin
                to_cnt <= '0;
            end else if (s_valid && to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (trig_go) begin
                start_addr <= ptr - PRE_V;
                auto_trig  <= auto_go;
            end
        end
    end

endmodule
